// File: rtl/multibuffer_queue.sv
// multibuffer_queue: circular bit-stream store spanning M_BUFF_NUM buffers.
// Fixed-width words are appended LSB-first at the tail. Fixed-width items are
// popped from the head once read_en has been held high long enough.
module multibuffer_queue #(
  parameter int Q_DATA_WIDTH      = 128,
  parameter int DATA_OUT_WIDTH    = 48,
  parameter int M_BUFF_NUM        = 4,
  parameter int M_BUFF_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [Q_DATA_WIDTH-1:0]   data_in,
  output logic                      waitrequest,
  input  logic                      read_en,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full
);

  localparam int BUF_BITS = 1 << M_BUFF_ADDR_WIDTH;
  localparam int CAP      = M_BUFF_NUM * BUF_BITS;
  localparam int PW       = $clog2(CAP);            // bit pointer width
  localparam int CW       = PW + 1;                 // count 0..CAP
  localparam int WORDS    = CAP / Q_DATA_WIDTH;
  localparam int WW       = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Buffers are laid out back to back, so the storage is one word-addressed
  // ring. Writes are always whole words, which means the write pointer only
  // ever lands on word boundaries and never straddles the wrap point.
  logic [WORDS-1:0][Q_DATA_WIDTH-1:0] mem_q, mem_d;
  logic [WW-1:0]                      wptr_q, wptr_d;
  logic [PW-1:0]                      rptr_q, rptr_d;
  logic [CW-1:0]                      count_q, count_d;
  logic [1:0]                         arm_q, arm_d;
  logic [DATA_OUT_WIDTH-1:0]          data_out_q, data_out_d;
  logic                               data_valid_q, data_valid_d;

  logic [CW-1:0]             free_bits;
  logic                      wr, pop;
  logic [CAP-1:0]            flat;
  logic [2*CAP-1:0]          dbl;
  logic [DATA_OUT_WIDTH-1:0] head_item;
  logic [PW:0]               rsum;

  // Status flags are pure functions of the stored bit count.
  always_comb begin
    free_bits   = CW'(CAP) - count_q;
    full        = free_bits < CW'(Q_DATA_WIDTH);
    almost_full = free_bits < CW'(2 * Q_DATA_WIDTH);
    empty       = count_q < CW'(DATA_OUT_WIDTH);
    waitrequest = full;
  end

  // Head extraction: doubling the ring lets an item that straddles the wrap
  // be read with a single part-select.
  always_comb begin
    flat      = mem_q;
    dbl       = {flat, flat};
    head_item = dbl[rptr_q +: DATA_OUT_WIDTH];
  end

  // Next-state: accept/pop decisions, pointer wrap, count and read arming.
  always_comb begin
    wr           = write_en && !full;
    pop          = read_en && (arm_q == 2'd2) && !empty;
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    rsum         = '0;
    data_out_d   = data_out_q;
    data_valid_d = pop;
    if (wr) begin
      mem_d[wptr_q] = data_in;
      wptr_d = (wptr_q == WW'(WORDS - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      data_out_d = head_item;
      rsum = {1'b0, rptr_q} + (PW + 1)'(DATA_OUT_WIDTH);
      if (rsum >= (PW + 1)'(CAP)) rsum = rsum - (PW + 1)'(CAP);
      rptr_d = rsum[PW-1:0];
    end
    count_d = count_q + (wr ? CW'(Q_DATA_WIDTH) : '0)
                      - (pop ? CW'(DATA_OUT_WIDTH) : '0);
    // Arm saturates at 2, so the third consecutive high edge is the first pop.
    if (!read_en)          arm_d = 2'd0;
    else if (arm_q == 2'd2) arm_d = 2'd2;
    else                   arm_d = arm_q + 2'd1;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      arm_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      arm_q        <= arm_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_multibuffer_queue.sv
// Bench for multibuffer_queue: directed scenarios with random data, checked
// against a bit-queue reference model plus per-scenario item ordering.
module tb_multibuffer_queue;
  localparam int QW  = 128;
  localparam int OW  = 48;
  localparam int CAP = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0, write_en = 1'b0, read_en = 1'b0;
  logic [QW-1:0] data_in = '0;
  logic          waitrequest, data_valid, full, empty, almost_full;
  logic [OW-1:0] data_out;

  multibuffer_queue #(
    .Q_DATA_WIDTH(QW), .DATA_OUT_WIDTH(OW), .M_BUFF_NUM(4), .M_BUFF_ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in),
    .waitrequest(waitrequest), .read_en(read_en), .data_out(data_out),
    .data_valid(data_valid), .full(full), .empty(empty), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model: the stored stream as a queue of bits, oldest at front.
  bit            mq[$];
  int            run = 0;          // consecutive read_en-high edges so far
  logic          m_valid = 1'b0;
  logic [OW-1:0] m_dout = '0;
  logic          m_pop;
  logic [OW-1:0] items[1024];
  int            rd_idx = 0, acc_words = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word w of the bit stream formed by concatenating items[] LSB first.
  function automatic logic [QW-1:0] word_of(int w);
    logic [QW-1:0] r;
    logic [OW-1:0] it;
    int b;
    r = '0;
    for (int j = 0; j < QW; j++) begin
      b = w * QW + j;
      it = items[b / OW];
      r[j] = it[b % OW];
    end
    return r;
  endfunction

  task automatic step(logic rs, logic we, logic [QW-1:0] din, logic re);
    int sz;
    rst = rs; write_en = we; data_in = din; read_en = re;
    @(posedge clk);
    m_pop = 1'b0;
    if (rs) begin
      mq.delete(); run = 0; m_valid = 1'b0; m_dout = '0;
    end else begin
      sz = mq.size();
      m_pop = re && (run >= 2) && (sz >= OW);
      if (m_pop) for (int j = 0; j < OW; j++) m_dout[j] = mq.pop_front();
      m_valid = m_pop;
      if (we && (CAP - sz >= QW)) begin
        for (int j = 0; j < QW; j++) mq.push_back(din[j]);
        acc_words++;
      end
      run = re ? run + 1 : 0;
    end
    #1;
    chk("data_valid", 128'(data_valid), 128'(m_valid));
    chk("data_out", 128'(data_out), 128'(m_dout));
    chk("empty", 128'(empty), 128'(mq.size() < OW));
    chk("full", 128'(full), 128'(CAP - mq.size() < QW));
    chk("almost_full", 128'(almost_full), 128'(CAP - mq.size() < 2 * QW));
    chk("waitrequest", 128'(waitrequest), 128'(CAP - mq.size() < QW));
    if (m_pop && rd_idx < 1024) begin
      chk("item_order", 128'(data_out), 128'(items[rd_idx]));
      rd_idx++;
    end
  endtask

  function automatic logic [QW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int wr_w, cyc;

    // Reset then one idle cycle.
    step(1, 0, '0, 0);
    step(0, 0, rnd_word(), 0);
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_afull", 128'(almost_full), 128'(0));
    chk("rst_wait", 128'(waitrequest), 128'(0));

    // 32 random items in 12 words, arm for 2 edges, then 32 back-to-back pops.
    for (int i = 0; i < 1024; i++) items[i] = {$urandom(), $urandom()};
    rd_idx = 0;
    for (int w = 0; w < 12; w++) step(0, 1, word_of(w), 0);
    step(0, 0, rnd_word(), 1);
    step(0, 0, rnd_word(), 1);
    chk("arm_no_valid", 128'(data_valid), 128'(0));
    for (int k = 0; k < 32; k++) step(0, 0, rnd_word(), 1);
    step(0, 0, rnd_word(), 0);
    chk("burst_items", 128'(rd_idx), 128'(32));
    chk("burst_empty", 128'(empty), 128'(1));

    // Single-cycle pulses consume nothing; 3-cycle bursts pop one item each.
    step(1, 0, '0, 0);
    for (int i = 0; i < 1024; i++) items[i] = OW'(i);
    rd_idx = 0;
    for (int w = 0; w < 12; w++) step(0, 1, word_of(w), 0);
    for (int k = 0; k < 32; k++) begin
      step(0, 0, rnd_word(), 1);
      step(0, 0, rnd_word(), 0);
    end
    chk("pulse_consumed", 128'(rd_idx), 128'(0));
    chk("pulse_empty", 128'(empty), 128'(0));
    for (int k = 0; k < 32; k++) begin
      step(0, 0, rnd_word(), 1);
      step(0, 0, rnd_word(), 1);
      step(0, 0, rnd_word(), 1);
      chk("burst3_value", 128'(data_out), 128'(k));
      step(0, 0, rnd_word(), 0);
    end
    chk("burst3_count", 128'(rd_idx), 128'(32));

    // Fill to capacity; extra writes are refused and dropped.
    step(1, 0, '0, 0);
    rd_idx = 0; acc_words = 0;
    for (int w = 0; w < 34; w++) begin
      step(0, 1, word_of(acc_words), 0);
      if (w == 31) begin
        chk("cap_full", 128'(full), 128'(1));
        chk("cap_afull", 128'(almost_full), 128'(1));
      end
      if (w == 30) chk("cap_minus1_full", 128'(full), 128'(0));
    end
    chk("cap_words", 128'(acc_words), 128'(32));
    for (int k = 0; k < 2 + 85 + 3; k++) step(0, 0, rnd_word(), 1);
    chk("drain_items", 128'(rd_idx), 128'(85));
    chk("drain_valid_end", 128'(data_valid), 128'(0));
    chk("drain_empty", 128'(empty), 128'(1));
    step(0, 0, rnd_word(), 0);

    // Concurrent stream of 1024 items, writes gated by waitrequest.
    step(1, 0, '0, 0);
    rd_idx = 0; wr_w = 0; cyc = 0;
    while (rd_idx < 1024 && cyc < 6000) begin
      if (wr_w < 384 && !waitrequest && $urandom_range(0, 3) != 0) begin
        step(0, 1, word_of(wr_w), 1);
        wr_w++;
      end else begin
        step(0, 0, rnd_word(), 1);
      end
      cyc++;
    end
    chk("stream_in_budget", 128'(cyc < 6000), 128'(1));
    chk("stream_items", 128'(rd_idx), 128'(1024));
    step(0, 0, rnd_word(), 0);
    chk("stream_empty", 128'(empty), 128'(1));

    // Reset mid-stream with both strobes high.
    for (int w = 0; w < 3; w++) step(0, 1, rnd_word(), 1);
    for (int k = 0; k < 3; k++) step(0, 1, rnd_word(), 1);
    step(1, 1, rnd_word(), 1);
    chk("midrst_empty", 128'(empty), 128'(1));
    chk("midrst_valid", 128'(data_valid), 128'(0));
    chk("midrst_dout", 128'(data_out), 128'(0));
    step(0, 0, rnd_word(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
